// File: rtl/control_subcmd_rectwriter.sv
// ----------------------------------------------------------------------------
// control_subcmd_rectwriter
//
// Rectangle-fill engine. On a request it latches a fill colour and a
// rectangle (x1, y1, width, height) and then streams one framebuffer byte per
// clock to the RAM write port. Bytes are ordered pixel-byte first (MSB byte
// down to byte 0), then column, then row. Addresses wrap modulo the address
// field width, so there is no clipping. Completion is signalled with a done
// level that stays high until the issuing stage acknowledges it.
//
// Ports
//   clk               in   memory-domain clock
//   reset             in   synchronous, active-high reset
//   enable            in   fill request level; must stay high for the fill
//   ack               in   completion acknowledge (only honoured in DONE)
//   x1, y1            in   start column / start row
//   width, height     in   rectangle size; 0 encodes the full panel size
//   color             in   fill colour, MSB byte is pixel byte index BPP-1
//   row, column       out  write address
//   pixel             out  byte-within-pixel select
//   data_out          out  write data byte
//   ram_write_enable  out  write strobe, one byte per high cycle
//   ram_access_start  out  pulse on the first write of a fill
//   done              out  fill complete, held until ack
// ----------------------------------------------------------------------------
module control_subcmd_rectwriter #(
    parameter int BYTES_PER_PIXEL           = 2,
    parameter int PIXEL_WIDTH               = 64,
    parameter int PIXEL_HEIGHT              = 32,
    parameter int NUM_COLUMN_ADDRESS_BITS   = 6,
    parameter int NUM_ROW_ADDRESS_BITS      = 5,
    parameter int NUM_PIXELCOLORSELECT_BITS = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 ack,
    input  logic [NUM_COLUMN_ADDRESS_BITS-1:0]   x1,
    input  logic [NUM_ROW_ADDRESS_BITS-1:0]      y1,
    input  logic [NUM_COLUMN_ADDRESS_BITS-1:0]   width,
    input  logic [NUM_ROW_ADDRESS_BITS-1:0]      height,
    input  logic [BYTES_PER_PIXEL*8-1:0]         color,
    output logic [NUM_ROW_ADDRESS_BITS-1:0]      row,
    output logic [NUM_COLUMN_ADDRESS_BITS-1:0]   column,
    output logic [NUM_PIXELCOLORSELECT_BITS-1:0] pixel,
    output logic [7:0]                           data_out,
    output logic                                 ram_write_enable,
    output logic                                 ram_access_start,
    output logic                                 done
);

    localparam int CW = NUM_COLUMN_ADDRESS_BITS;
    localparam int RW = NUM_ROW_ADDRESS_BITS;
    localparam int PW = NUM_PIXELCOLORSELECT_BITS;
    localparam int DW = BYTES_PER_PIXEL * 8;
    localparam int PIX_TOP_I = BYTES_PER_PIXEL - 1;

    // Size counters are one bit wider than the fields so that a zero field can
    // be expanded to the full panel dimension.
    localparam logic [CW:0]   FULL_W  = PIXEL_WIDTH[CW:0];
    localparam logic [RW:0]   FULL_H  = PIXEL_HEIGHT[RW:0];
    localparam logic [CW:0]   ONE_W   = 1;
    localparam logic [RW:0]   ONE_H   = 1;
    localparam logic [PW-1:0] ONE_P   = 1;
    localparam logic [PW-1:0] PIX_TOP = PIX_TOP_I[PW-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_REARM = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   color_q, color_d;
    logic [CW-1:0]   x1_q, x1_d;
    logic [RW-1:0]   y1_q, y1_d;
    logic [CW:0]     w_q, w_d;
    logic [RW:0]     h_q, h_d;
    logic [CW:0]     col_off_q, col_off_d;
    logic [RW:0]     row_off_q, row_off_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   column_q, column_d;
    logic [7:0]      data_q, data_d;
    logic            we_q, we_d;
    logic            start_q, start_d;
    logic            done_q, done_d;

    logic            last_pix, last_col, last_row;

    // Pick the colour byte addressed by a pixel byte index.
    function automatic logic [7:0] byte_sel(input logic [DW-1:0] c,
                                            input logic [PW-1:0] p);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
            if (p == i[PW-1:0]) r = c[i*8 +: 8];
        end
        return r;
    endfunction

    assign last_pix = (pix_q == '0);
    assign last_col = (col_off_q == (w_q - ONE_W));
    assign last_row = (row_off_q == (h_q - ONE_H));

    always_comb begin
        state_d   = state_q;
        color_d   = color_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        w_d       = w_q;
        h_d       = h_q;
        col_off_d = col_off_q;
        row_off_d = row_off_q;
        pix_d     = pix_q;
        row_d     = row_q;
        column_d  = column_q;
        data_d    = data_q;
        we_d      = 1'b0;
        start_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    color_d   = color;
                    x1_d      = x1;
                    y1_d      = y1;
                    w_d       = (width  == '0) ? FULL_W : {1'b0, width};
                    h_d       = (height == '0) ? FULL_H : {1'b0, height};
                    col_off_d = '0;
                    row_off_d = '0;
                    // First byte is presented straight from the inputs so the
                    // write lands on the cycle after enable is sampled.
                    pix_d     = PIX_TOP;
                    row_d     = y1;
                    column_d  = x1;
                    data_d    = byte_sel(color, PIX_TOP);
                    we_d      = 1'b1;
                    start_d   = 1'b1;
                    state_d   = S_WRITE;
                end
            end

            S_WRITE: begin
                if (!enable) begin
                    // Abort: stop writing, no done, address outputs hold.
                    state_d = S_IDLE;
                end else if (last_pix && last_col && last_row) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d = 1'b1;
                    if (!last_pix) begin
                        pix_d = pix_q - ONE_P;
                    end else begin
                        pix_d = PIX_TOP;
                        if (!last_col) begin
                            col_off_d = col_off_q + ONE_W;
                        end else begin
                            col_off_d = '0;
                            row_off_d = row_off_q + ONE_H;
                        end
                    end
                    // Offsets are truncated to the field width: wrap, no clip.
                    row_d    = y1_q + row_off_d[RW-1:0];
                    column_d = x1_q + col_off_d[CW-1:0];
                    data_d   = byte_sel(color_q, pix_d);
                end
            end

            S_DONE: begin
                if (ack) begin
                    state_d = S_REARM;
                end else begin
                    done_d = 1'b1;
                end
            end

            S_REARM: begin
                // A request left high after completion must not start a
                // second fill; wait for it to drop first.
                if (!enable) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            color_q   <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_off_q <= '0;
            row_off_q <= '0;
            pix_q     <= '0;
            row_q     <= '0;
            column_q  <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            color_q   <= color_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            w_q       <= w_d;
            h_q       <= h_d;
            col_off_q <= col_off_d;
            row_off_q <= row_off_d;
            pix_q     <= pix_d;
            row_q     <= row_d;
            column_q  <= column_d;
            data_q    <= data_d;
            we_q      <= we_d;
            start_q   <= start_d;
            done_q    <= done_d;
        end
    end

    assign row              = row_q;
    assign column           = column_q;
    assign pixel            = pix_q;
    assign data_out         = data_q;
    assign ram_write_enable = we_q;
    assign ram_access_start = start_q;
    assign done             = done_q;

endmodule

// File: tb/tb_control_subcmd_rectwriter.sv
// ----------------------------------------------------------------------------
// Testbench for control_subcmd_rectwriter. The expected write stream for a
// fill is computed from the rectangle arithmetically: write index i maps to
// pixel byte BPP-1-(i mod BPP), column (x1 + (i/BPP) mod W) mod 64 and row
// (y1 + i/(BPP*W)) mod 32.
// ----------------------------------------------------------------------------
module tb_control_subcmd_rectwriter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        ack;
    logic [5:0]  x1;
    logic [4:0]  y1;
    logic [5:0]  width;
    logic [4:0]  height;
    logic [15:0] color;
    logic [4:0]  row;
    logic [5:0]  column;
    logic [0:0]  pixel;
    logic [7:0]  data_out;
    logic        ram_write_enable;
    logic        ram_access_start;
    logic        done;

    int checks;
    int errors;

    control_subcmd_rectwriter dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .ack              (ack),
        .x1               (x1),
        .y1               (y1),
        .width            (width),
        .height           (height),
        .color            (color),
        .row              (row),
        .column           (column),
        .pixel            (pixel),
        .data_out         (data_out),
        .ram_write_enable (ram_write_enable),
        .ram_access_start (ram_access_start),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_row"},   32'(row), 0);
        chk({tag, "_col"},   32'(column), 0);
        chk({tag, "_pix"},   32'(pixel), 0);
        chk({tag, "_data"},  32'(data_out), 0);
        chk({tag, "_we"},    32'(ram_write_enable), 0);
        chk({tag, "_start"}, 32'(ram_access_start), 0);
        chk({tag, "_done"},  32'(done), 0);
    endtask

    // Called on a negedge. Leaves enable high after a completed fill.
    // abort_after > 0 drops enable so that exactly that many bytes get written.
    task automatic run_fill(input logic [15:0] c, input logic [5:0] xx,
                            input logic [4:0] yy, input logic [5:0] ww,
                            input logic [4:0] hh, input int abort_after);
        int w_i, h_i, total, n, p, col_e, row_e, dat_e;
        w_i   = (ww == 0) ? 64 : int'(ww);
        h_i   = (hh == 0) ? 32 : int'(hh);
        total = w_i * h_i * 2;
        n     = (abort_after > 0) ? abort_after : total;
        color  = c;
        x1     = xx;
        y1     = yy;
        width  = ww;
        height = hh;
        enable = 1'b1;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            p     = 1 - (i % 2);
            col_e = (int'(xx) + (i / 2) % w_i) % 64;
            row_e = (int'(yy) + i / (2 * w_i)) % 32;
            dat_e = (int'(c) >> (8 * p)) & 8'hff;
            chk("wr_we",    32'(ram_write_enable), 1);
            chk("wr_row",   32'(row), 32'(row_e));
            chk("wr_col",   32'(column), 32'(col_e));
            chk("wr_pix",   32'(pixel), 32'(p));
            chk("wr_data",  32'(data_out), 32'(dat_e));
            chk("wr_start", 32'(ram_access_start), (i == 0) ? 1 : 0);
            chk("wr_done",  32'(done), 0);
            if (i == 0) begin
                // Scramble the request inputs; the latched fill must not notice.
                color  = 16'($urandom);
                x1     = 6'($urandom);
                y1     = 5'($urandom);
                width  = 6'($urandom);
                height = 5'($urandom);
            end
            if (abort_after > 0 && i == n - 1) enable = 1'b0;
        end
        if (abort_after > 0) begin
            repeat (4) begin
                @(negedge clk);
                chk("abort_we",   32'(ram_write_enable), 0);
                chk("abort_done", 32'(done), 0);
            end
        end else begin
            @(negedge clk);
            chk("end_we",   32'(ram_write_enable), 0);
            chk("end_done", 32'(done), 1);
        end
    endtask

    // Called on a negedge while done is high: acknowledge and drop enable.
    task automatic ack_release();
        ack = 1'b1;
        @(negedge clk);
        chk("ack_done", 32'(done), 0);
        chk("ack_we",   32'(ram_write_enable), 0);
        ack    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        x1     = '0;
        y1     = '0;
        width  = '0;
        height = '0;
        color  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // ack outside DONE has no effect.
        ack = 1'b1;
        @(negedge clk);
        chk("idle_ack_done", 32'(done), 0);
        chk("idle_ack_we",   32'(ram_write_enable), 0);
        ack = 1'b0;

        // Directed 2x2 fill, then done hold and re-arm behaviour.
        run_fill(16'hABCD, 6'd3, 5'd1, 6'd2, 5'd2, 0);
        repeat (10) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 1);
            chk("hold_we",   32'(ram_write_enable), 0);
        end
        ack = 1'b1;
        @(negedge clk);
        chk("ackd_done", 32'(done), 0);
        ack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rearm_we",   32'(ram_write_enable), 0);
            chk("rearm_done", 32'(done), 0);
        end
        enable = 1'b0;
        @(negedge clk);

        // Full-panel fill via zero width/height.
        run_fill(16'h1234, 6'd0, 5'd0, 6'd0, 5'd0, 0);
        ack_release();

        // Wrapping rectangle.
        run_fill(16'h5A3C, 6'd62, 5'd31, 6'd4, 5'd2, 0);
        ack_release();

        // Randomised fills.
        for (int k = 0; k < 8; k++) begin
            run_fill(16'($urandom), 6'($urandom), 5'($urandom),
                     6'($urandom_range(1, 9)), 5'($urandom_range(1, 4)), 0);
            ack_release();
        end

        // Abort after 5 writes of a 2x2 fill, then a fresh fill.
        run_fill(16'hBEEF, 6'd10, 5'd7, 6'd2, 5'd2, 5);
        run_fill(16'hBEEF, 6'd10, 5'd7, 6'd2, 5'd2, 0);
        ack_release();

        // Reset in the middle of a fill.
        color  = 16'hC0DE;
        x1     = 6'd20;
        y1     = 5'd9;
        width  = 6'd4;
        height = 5'd4;
        enable = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("pre_rst_we", 32'(ram_write_enable), 1);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_we",   32'(ram_write_enable), 0);
            chk("postrst_done", 32'(done), 0);
        end

        // Recovery fill after reset.
        run_fill(16'h0F0F, 6'd1, 5'd2, 6'd3, 5'd1, 0);
        ack_release();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_subcmd_rectwriter.md
Name: control_subcmd_rectwriter

Overview:
Rectangle-fill engine that sits directly downstream of the fill-panel/fill-area command stages. It takes a latched colour and a rectangle (x1, y1, width, height) and streams one framebuffer byte per clock to the RAM write port as row/column/pixel/data_out with a write strobe. It reports completion with a done level that is held until the issuing command stage acknowledges it.

Parameters:
BYTES_PER_PIXEL, 2, bytes per pixel colour; pixel byte index runs BYTES_PER_PIXEL-1 down to 0.
PIXEL_WIDTH, 64, panel width in pixels.
PIXEL_HEIGHT, 32, panel height in pixels.
NUM_COLUMN_ADDRESS_BITS, 6, column address width, equal to clog2(PIXEL_WIDTH).
NUM_ROW_ADDRESS_BITS, 5, row address width, equal to clog2(PIXEL_HEIGHT).
NUM_PIXELCOLORSELECT_BITS, 1, pixel byte select width, equal to clog2(BYTES_PER_PIXEL).

Ports:
clk  in  1  single clock (memory clock domain).
reset  in  1  synchronous, active-high reset.
enable  in  1  level request; sampled in IDLE to start a fill, and must stay high for the whole fill.
ack  in  1  completion acknowledge from the issuing stage.
x1  in  NUM_COLUMN_ADDRESS_BITS  start column.
y1  in  NUM_ROW_ADDRESS_BITS  start row.
width  in  NUM_COLUMN_ADDRESS_BITS  columns to fill; 0 encodes PIXEL_WIDTH.
height  in  NUM_ROW_ADDRESS_BITS  rows to fill; 0 encodes PIXEL_HEIGHT.
color  in  BYTES_PER_PIXEL*8  fill colour; MSB byte is pixel index BYTES_PER_PIXEL-1.
row  out  NUM_ROW_ADDRESS_BITS  write row address.
column  out  NUM_COLUMN_ADDRESS_BITS  write column address.
pixel  out  NUM_PIXELCOLORSELECT_BITS  byte-within-pixel select.
data_out  out  8  write data.
ram_write_enable  out  1  write strobe; one byte is written per high cycle.
ram_access_start  out  1  one-cycle pulse coincident with the first write of a fill.
done  out  1  fill complete; held until ack.

Behaviour:
- Reset: all outputs 0; state IDLE; colour, geometry and counters cleared. Reset mid-fill aborts on the next edge with no further writes and no done.
- States: IDLE -> WRITE -> DONE -> REARM -> IDLE.
- IDLE, enable=1:
  - Latch color, x1, y1, width, height.
  - A zero width or height is expanded to the panel dimension in a counter one bit wider than the field.
  - Go to WRITE. The first write appears on the cycle after enable is sampled (1-cycle latency).
- WRITE: one byte per cycle with ram_write_enable=1.
  - data_out = color byte selected by pixel.
  - Iteration order, innermost first: pixel from BYTES_PER_PIXEL-1 down to 0; then column x1 .. x1+W-1; then row y1 .. y1+H-1.
  - row and column are computed modulo 2^field-width, so rectangles that overrun the panel wrap to 0. There is no clipping.
  - ram_access_start=1 only on the first write cycle of the fill.
  - Total write cycles = W*H*BYTES_PER_PIXEL, contiguous with no bubbles.
- After the last byte, go to DONE: write_enable=0, done=1 from the next cycle.
- enable dropping during WRITE aborts the fill:
  - write_enable=0 from the next cycle.
  - Return to IDLE without done.
  - Bytes already written stay written.
- DONE: done held high while ack=0. When ack=1, done=0 on the next cycle and the state moves to REARM. ack in any other state is ignored.
- REARM: wait for enable=0, then go to IDLE. A held-high enable never triggers a second fill.
- row/column/pixel/data_out hold their last values outside WRITE; ram_write_enable is the only qualifier.
- Inputs are not re-sampled during a fill. Changing color or geometry mid-fill has no effect.

Test Plan:
- BPP=2, color=0xABCD, x1=3, y1=1, width=2, height=2 -> 8 contiguous writes: (r1,c3,p1,AB),(r1,c3,p0,CD),(r1,c4,p1,AB),(r1,c4,p0,CD), then the same sequence for r2; ram_access_start on the first write only; done high on the cycle after the last write.
- width=0, height=0, color=0x1234 -> 4096 writes covering every (row,col,pixel) once; row 31/col 63/pixel 0 is last.
- x1=62, y1=31, width=4, height=2 -> column sequence 62,63,0,1; row sequence 31,0.
- Fill completes, ack held low for 10 cycles -> done high for all 10 cycles; ack=1 -> done low on the next cycle; enable still high -> no new writes until enable low then high again.
- enable drops after 5 writes of a 2x2 fill -> no write on the following cycles, done never asserted, next enable starts a fresh fill from (y1,x1,p1).
- reset asserted mid-WRITE -> all outputs 0 on the next cycle, state IDLE, no done.
